// File: rtl/ram_pkg.sv
// Shared definitions for the byte-enable single-port RAM: read-during-write
// mode codes and the post-reset clear-sweep states.
package ram_pkg;

    localparam int RD_READ_FIRST  = 0;
    localparam int RD_WRITE_FIRST = 1;
    localparam int RD_NO_CHANGE   = 2;

    typedef enum logic {
        INIT,
        RUN
    } ram_init_state_t;

endpackage

// File: rtl/ram_bank_be.sv
// Bare synchronous-read storage array with byte-lane writes, shaped for
// block-RAM inference; the read register only updates when rd_en_i is high.
module ram_bank_be
    import ram_pkg::*;
#(
    parameter  int DATAWIDTH = 32,
    parameter  int ADDRWIDTH = 9,
    parameter  int BYTEWIDTH = 8,
    parameter  int RDMODE    = RD_READ_FIRST,
    localparam int NBYTES    = DATAWIDTH / BYTEWIDTH
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 rd_en_i,
    input  logic [NBYTES-1:0]    we_i,
    input  logic [ADDRWIDTH-1:0] addr_i,
    input  logic [DATAWIDTH-1:0] wdata_i,
    output logic [DATAWIDTH-1:0] rdata_o
);

    logic [DATAWIDTH-1:0] mem_q [2**ADDRWIDTH];
    logic [DATAWIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NBYTES; i++) begin
            if (we_i[i]) begin
                mem_q[addr_i][i*BYTEWIDTH +: BYTEWIDTH] <= wdata_i[i*BYTEWIDTH +: BYTEWIDTH];
            end
        end
    end

    // Read register samples the pre-write word unless WRITE_FIRST forwards the written lanes.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (RDMODE == RD_WRITE_FIRST && we_i[i]) begin
                    rdata_q[i*BYTEWIDTH +: BYTEWIDTH] <= wdata_i[i*BYTEWIDTH +: BYTEWIDTH];
                end else begin
                    rdata_q[i*BYTEWIDTH +: BYTEWIDTH] <= mem_q[addr_i][i*BYTEWIDTH +: BYTEWIDTH];
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_blk_sp_be.sv
// Single-port block RAM with byte-lane writes, selectable read-during-write
// behaviour, optional output register and a post-reset clear sweep.
module ram_blk_sp_be
    import ram_pkg::*;
#(
    parameter  int                   DATAWIDTH  = 32,
    parameter  int                   ADDRWIDTH  = 9,
    parameter  int                   BYTEWIDTH  = 8,
    parameter  int                   RDMODE     = RD_READ_FIRST,
    parameter  int                   OUT_REG    = 1,
    parameter  int                   INIT_CLEAR = 1,
    parameter  logic [DATAWIDTH-1:0] INIT_VALUE = '0,
    localparam int                   NBYTES     = DATAWIDTH / BYTEWIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic                 we,
    input  logic [NBYTES-1:0]    be,
    input  logic [ADDRWIDTH-1:0] addr,
    input  logic [DATAWIDTH-1:0] wr_data,
    output logic                 busy,
    output logic                 rd_valid,
    output logic [DATAWIDTH-1:0] rd_data
);

    if (DATAWIDTH % BYTEWIDTH != 0) begin : g_bad_width
        $error("DATAWIDTH must be a multiple of BYTEWIDTH");
    end
    if (RDMODE < RD_READ_FIRST || RDMODE > RD_NO_CHANGE) begin : g_bad_mode
        $error("RDMODE must be 0, 1 or 2");
    end

    localparam logic [ADDRWIDTH-1:0] CNT_ONE = {{(ADDRWIDTH-1){1'b0}}, 1'b1};

    ram_init_state_t      state_q;
    logic [ADDRWIDTH-1:0] cnt_q;
    logic                 accept;
    logic                 vld_d;
    logic                 vld_p0_q;
    logic [NBYTES-1:0]    bank_we;
    logic [ADDRWIDTH-1:0] bank_addr;
    logic [DATAWIDTH-1:0] bank_wdata;
    logic [DATAWIDTH-1:0] bank_rdata;

    assign busy   = (state_q == INIT);
    assign accept = req & ~busy & ~reset;
    // NO_CHANGE suppresses the strobe for writes so rd_data keeps its last read.
    assign vld_d  = accept & ((RDMODE != RD_NO_CHANGE) | ~we);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= (INIT_CLEAR != 0) ? INIT : RUN;
            cnt_q   <= '0;
        end else if (state_q == INIT) begin
            cnt_q <= cnt_q + CNT_ONE;
            if (&cnt_q) begin
                state_q <= RUN;
            end
        end
    end

    always_comb begin
        bank_we    = '0;
        bank_addr  = addr;
        bank_wdata = wr_data;
        if (!reset) begin
            if (busy) begin
                bank_we    = '1;
                bank_addr  = cnt_q;
                bank_wdata = INIT_VALUE;
            end else if (accept && we) begin
                bank_we = be;
            end
        end
    end

    ram_bank_be #(
        .DATAWIDTH (DATAWIDTH),
        .ADDRWIDTH (ADDRWIDTH),
        .BYTEWIDTH (BYTEWIDTH),
        .RDMODE    (RDMODE)
    ) u_bank (
        .clk_i   (clk),
        .reset_i (reset),
        .rd_en_i (vld_d),
        .we_i    (bank_we),
        .addr_i  (bank_addr),
        .wdata_i (bank_wdata),
        .rdata_o (bank_rdata)
    );

    // Stage p0: array read register, qualified by vld_p0_q
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0_q <= 1'b0;
        end else begin
            vld_p0_q <= vld_d;
        end
    end

    // Stage p1: optional output register, loaded only on valid so data holds between strobes
    if (OUT_REG != 0) begin : g_out_reg
        logic                 vld_p1_q;
        logic [DATAWIDTH-1:0] rd_data_p1_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                vld_p1_q     <= 1'b0;
                rd_data_p1_q <= '0;
            end else begin
                vld_p1_q <= vld_p0_q;
                if (vld_p0_q) begin
                    rd_data_p1_q <= bank_rdata;
                end
            end
        end

        assign rd_valid = vld_p1_q;
        assign rd_data  = rd_data_p1_q;
    end else begin : g_no_out_reg
        assign rd_valid = vld_p0_q;
        assign rd_data  = bank_rdata;
    end

endmodule

// File: tb/tb_ram_blk_sp_be.sv
// Bench for ram_blk_sp_be: three instances (READ_FIRST/OUT_REG=1, WRITE_FIRST/OUT_REG=0,
// NO_CHANGE/OUT_REG=1) share stimulus and are checked every cycle against a word-level model.
module tb_ram_blk_sp_be;
    import ram_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int NB    = 4;
    localparam int DEPTH = 16;
    localparam int NCYC  = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, req, we;
    logic [NB-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic [2:0]    busy_w, vld_w;
    logic [DW-1:0] rdat_w [3];

    ram_blk_sp_be #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .BYTEWIDTH(8), .RDMODE(RD_READ_FIRST),
                    .OUT_REG(1), .INIT_CLEAR(1), .INIT_VALUE(32'h0)) u_rf (
        .clk(clk), .reset(reset), .req(req), .we(we), .be(be), .addr(addr), .wr_data(wr_data),
        .busy(busy_w[0]), .rd_valid(vld_w[0]), .rd_data(rdat_w[0]));

    ram_blk_sp_be #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .BYTEWIDTH(8), .RDMODE(RD_WRITE_FIRST),
                    .OUT_REG(0), .INIT_CLEAR(1), .INIT_VALUE(32'h0)) u_wf (
        .clk(clk), .reset(reset), .req(req), .we(we), .be(be), .addr(addr), .wr_data(wr_data),
        .busy(busy_w[1]), .rd_valid(vld_w[1]), .rd_data(rdat_w[1]));

    ram_blk_sp_be #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .BYTEWIDTH(8), .RDMODE(RD_NO_CHANGE),
                    .OUT_REG(1), .INIT_CLEAR(1), .INIT_VALUE(32'h0)) u_nc (
        .clk(clk), .reset(reset), .req(req), .we(we), .be(be), .addr(addr), .wr_data(wr_data),
        .busy(busy_w[2]), .rd_valid(vld_w[2]), .rd_data(rdat_w[2]));

    // Reference model: instance index d equals its RDMODE.
    logic [DW-1:0] mem_m [DEPTH];
    int            sweep_left;
    int            cyc;
    bit            sched_v [3][NCYC];
    logic [DW-1:0] sched_d [3][NCYC];
    logic [DW-1:0] exp_d [3];
    int            checks, errors;

    function automatic int oreg_of(input int d);
        return (d == 1) ? 0 : 1;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                            input logic [NB-1:0] lanes);
        logic [DW-1:0] mask;
        mask = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit q, input bit w, input logic [NB-1:0] b,
                        input logic [AW-1:0] a, input logic [DW-1:0] wd);
        int e;
        logic [DW-1:0] oldw, neww;
        reset = r; req = q; we = w; be = b; addr = a; wr_data = wd;
        e = cyc + 1;
        if (e + 2 >= NCYC) begin
            $display("FAIL cycle_budget: got %0d expected below %0d", e, NCYC - 2);
            $fatal(1, "cycle budget exhausted");
        end
        if (r) begin
            sweep_left = DEPTH;
            for (int d = 0; d < 3; d++)
                for (int k = 0; k < 3; k++) sched_v[d][e+k] = 1'b0;
        end else begin
            if (q && sweep_left == 0) begin
                oldw = mem_m[a];
                neww = w ? merge(oldw, wd, b) : oldw;
                mem_m[a] = neww;
                for (int d = 0; d < 3; d++) begin
                    if (d != RD_NO_CHANGE || !w) begin
                        sched_v[d][e+oreg_of(d)] = 1'b1;
                        sched_d[d][e+oreg_of(d)] = (w && d == RD_WRITE_FIRST) ? neww : oldw;
                    end
                end
            end
            if (sweep_left > 0) begin
                sweep_left--;
                if (sweep_left == 0)
                    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
            end
        end
        @(posedge clk);
        #1;
        cyc = e;
        for (int d = 0; d < 3; d++) begin
            if (sched_v[d][e]) exp_d[d] = sched_d[d][e];
            else if (r) exp_d[d] = '0;
            check($sformatf("busy[%0d]", d), DW'(busy_w[d]), DW'(sweep_left > 0));
            check($sformatf("rd_valid[%0d]", d), DW'(vld_w[d]), DW'(sched_v[d][e]));
            check($sformatf("rd_data[%0d]", d), rdat_w[d], exp_d[d]);
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    typedef struct {
        bit            w;
        logic [NB-1:0] b;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [DW-1:0] e_rf;
        logic [DW-1:0] e_wf;
        logic [DW-1:0] e_nc;
    } vec_t;

    vec_t tbl [10];
    int   busy_cnt;
    int   pulse_cnt [3];

    initial begin
        tbl[0] = '{1'b1, 4'hF, 4'd3,  32'hAABBCCDD, 32'h00000000, 32'hAABBCCDD, 32'h00000000};
        tbl[1] = '{1'b1, 4'h5, 4'd3,  32'h11223344, 32'hAABBCCDD, 32'hAA22CC44, 32'h00000000};
        tbl[2] = '{1'b0, 4'h0, 4'd3,  32'h00000000, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44};
        tbl[3] = '{1'b1, 4'hF, 4'd5,  32'h12345678, 32'h00000000, 32'h12345678, 32'hAA22CC44};
        tbl[4] = '{1'b0, 4'h0, 4'd5,  32'h00000000, 32'h12345678, 32'h12345678, 32'h12345678};
        tbl[5] = '{1'b1, 4'h0, 4'd5,  32'hFFFFFFFF, 32'h12345678, 32'h12345678, 32'h12345678};
        tbl[6] = '{1'b0, 4'h0, 4'd5,  32'h00000000, 32'h12345678, 32'h12345678, 32'h12345678};
        tbl[7] = '{1'b1, 4'h8, 4'd15, 32'hDEADBEEF, 32'h00000000, 32'hDE000000, 32'h12345678};
        tbl[8] = '{1'b0, 4'h0, 4'd15, 32'h00000000, 32'hDE000000, 32'hDE000000, 32'hDE000000};
        tbl[9] = '{1'b0, 4'h0, 4'd0,  32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};

        checks = 0; errors = 0; cyc = 0; sweep_left = 0;
        for (int d = 0; d < 3; d++) exp_d[d] = '0;
        reset = 1'b1; req = 1'b0; we = 1'b0; be = '0; addr = '0; wr_data = '0;

        // Reset, then count the sweep while requests are held high.
        step(1'b1, 1'b0, 1'b0, '0, '0, '0);
        busy_cnt = busy_w[0] ? 1 : 0;
        for (int i = 0; i < 40 && busy_w[0]; i++) begin
            step(1'b0, 1'b1, 1'b0, '0, AW'(i), '0);
            if (busy_w[0]) busy_cnt++;
        end
        check("sweep_length", DW'(busy_cnt), DW'(DEPTH));

        // Back-to-back reads of the cleared array.
        for (int d = 0; d < 3; d++) pulse_cnt[d] = 0;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 1'b0, '0, AW'(i), '0);
            for (int d = 0; d < 3; d++) if (vld_w[d]) pulse_cnt[d]++;
        end
        for (int k = 0; k < 2; k++) begin
            idle();
            for (int d = 0; d < 3; d++) if (vld_w[d]) pulse_cnt[d]++;
        end
        for (int d = 0; d < 3; d++) check($sformatf("stream_pulses[%0d]", d), DW'(pulse_cnt[d]), DW'(DEPTH));

        // Directed vectors with per-mode expected data.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, tbl[i].w, tbl[i].b, tbl[i].a, tbl[i].wd);
            check($sformatf("tbl%0d_wf_vld", i), DW'(vld_w[1]), DW'(1));
            check($sformatf("tbl%0d_wf_data", i), rdat_w[1], tbl[i].e_wf);
            idle();
            check($sformatf("tbl%0d_rf_vld", i), DW'(vld_w[0]), DW'(1));
            check($sformatf("tbl%0d_rf_data", i), rdat_w[0], tbl[i].e_rf);
            check($sformatf("tbl%0d_nc_vld", i), DW'(vld_w[2]), DW'(!tbl[i].w));
            check($sformatf("tbl%0d_nc_data", i), rdat_w[2], tbl[i].e_nc);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(1'b0, ($urandom % 4) != 0, $urandom % 2, NB'($urandom), AW'($urandom), $urandom);
        end
        idle(); idle();

        // Reset part-way through the sweep restarts it from address 0.
        step(1'b1, 1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, '0, AW'(i), '0);
        check("midsweep_busy", DW'(busy_w[0]), DW'(1));
        step(1'b1, 1'b0, 1'b0, '0, '0, '0);
        busy_cnt = busy_w[0] ? 1 : 0;
        for (int i = 0; i < 40 && busy_w[0]; i++) begin
            step(1'b0, 1'b0, 1'b0, '0, '0, '0);
            if (busy_w[0]) busy_cnt++;
        end
        check("resweep_length", DW'(busy_cnt), DW'(DEPTH));
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, '0, AW'(i), '0);
        idle(); idle();

        // Reset with reads in flight drops them and clears rd_data.
        step(1'b0, 1'b1, 1'b1, 4'hF, 4'd3, 32'hCAFEF00D);
        step(1'b0, 1'b1, 1'b1, 4'hF, 4'd4, 32'h0BADBEEF);
        step(1'b0, 1'b1, 1'b0, '0, 4'd3, '0);
        step(1'b0, 1'b1, 1'b0, '0, 4'd4, '0);
        step(1'b1, 1'b0, 1'b0, '0, '0, '0);
        for (int d = 0; d < 3; d++) pulse_cnt[d] = 0;
        for (int k = 0; k < 4; k++) begin
            idle();
            for (int d = 0; d < 3; d++) if (vld_w[d]) pulse_cnt[d]++;
        end
        for (int d = 0; d < 3; d++) begin
            check($sformatf("post_reset_pulses[%0d]", d), DW'(pulse_cnt[d]), DW'(0));
            check($sformatf("post_reset_data[%0d]", d), rdat_w[d], 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_blk_sp_be.md
Name: ram_blk_sp_be

Overview:
Parameterised single-port block RAM, successor to the team's basic single-port RAM. Adds per-byte write enables, a selectable read-during-write mode and an optional output pipeline register with a valid strobe. Also adds a post-reset clear sweep with a busy flag. Used as tag/data storage in cache and buffer blocks that need masked writes and a known-zero memory after reset.

Parameters:
DATAWIDTH, 32, word width in bits; must be a multiple of BYTEWIDTH (elaboration error otherwise)
ADDRWIDTH, 9, address width; depth = 2^ADDRWIDTH words
BYTEWIDTH, 8, bits per write-enable lane; NBYTES = DATAWIDTH/BYTEWIDTH
RDMODE, 0, read-during-write mode: 0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE
OUT_REG, 1, 0 = data one cycle after request; 1 = one extra output register stage
INIT_CLEAR, 1, 1 = write INIT_VALUE to every word after reset; 0 = no sweep
INIT_VALUE, 0, DATAWIDTH-wide clear value

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
req  in  1  request strobe; accepted when req & ~busy
we  in  1  1 = write request, 0 = read request
be  in  NBYTES  byte-lane write enables; be[i] gates wr_data[i*BYTEWIDTH +: BYTEWIDTH]
addr  in  ADDRWIDTH  word address
wr_data  in  DATAWIDTH  write data
busy  out  1  high during the clear sweep; requests are ignored while high
rd_valid  out  1  one-cycle strobe qualifying rd_data
rd_data  out  DATAWIDTH  read data, held between strobes

Behaviour:
- Reset values: busy = INIT_CLEAR; rd_valid = 0; rd_data = 0; all pipeline valid bits = 0.
- Memory contents are not touched by reset except through the sweep.
- State machine: INIT, RUN.
  - Reset enters INIT if INIT_CLEAR = 1, otherwise RUN.
  - INIT: counter starts at 0 and writes INIT_VALUE (all lanes) to one address per cycle. busy = 1; req is ignored and produces no rd_valid.
  - After address 2^ADDRWIDTH-1 is written, the next state is RUN and busy drops. Sweep length is exactly 2^ADDRWIDTH cycles.
  - Reset asserted mid-sweep restarts the sweep at address 0.
- Accepted write: the array updates only the lanes with be[i] = 1. we = 1 with be = 0 is a legal no-op write.
- Latency: an accepted request at edge N produces rd_valid/rd_data at edge N+1+OUT_REG. Throughput is one request per cycle, with no bubbles.
- rd_valid generation:
  - RDMODE 0/1: pulses for every accepted request, read or write.
  - RDMODE 2: pulses for accepted reads only.
- rd_data on an accepted write:
  - READ_FIRST: returns the word before the write.
  - WRITE_FIRST: returns the merged word (new lanes where be = 1, old lanes elsewhere).
  - NO_CHANGE: rd_data holds its previous value.
- Back-to-back write then read to the same address: the read returns the merged data. No hazard, because the array is written on the first edge.
- rd_data changes only on edges where the final-stage valid is 1; otherwise it holds.
- Reset during RUN drops all in-flight pipeline valids. No rd_valid is emitted for requests accepted before reset.
- Out-of-range addresses are impossible (full 2^ADDRWIDTH depth).

Decomposition:
- Shared package ram_pkg:
  - RDMODE constants RD_READ_FIRST = 0, RD_WRITE_FIRST = 1, RD_NO_CHANGE = 2.
  - State enum ram_init_state_t {INIT, RUN}.
- Sub-module ram_bank_be:
  - Bare storage array, synchronous read with byte-lane write, parameterised by DATAWIDTH/ADDRWIDTH/BYTEWIDTH/RDMODE.
  - Written for block-RAM inference.
  - The top level owns the sweep FSM, the request mux (sweep vs user) and the valid/output pipeline.

Test Plan:
- Reset with INIT_CLEAR = 1, ADDRWIDTH = 4 -> busy high for exactly 16 cycles. Then reading each address 0..15 returns 0, and req during busy yields no rd_valid.
- Write 0xAABBCCDD be = 4'b1111 to addr 3, then write 0x11223344 be = 4'b0101 to addr 3, then read addr 3 -> rd_data = 0xAA22CC44 at N+2 (OUT_REG = 1) and at N+1 (OUT_REG = 0).
- Same-address write with old = 0x0, new = 0x12345678 be = all -> rd_data = 0x0 (READ_FIRST) / 0x12345678 (WRITE_FIRST) / unchanged and no rd_valid (NO_CHANGE).
- Stream 16 consecutive reads to addrs 0..15 -> 16 consecutive rd_valid pulses in address order, no gaps, first at N+1+OUT_REG.
- Assert reset at sweep address 7, release -> sweep restarts at 0 and busy lasts a further full 2^ADDRWIDTH cycles.
- Issue 2 reads, assert reset the next cycle -> no rd_valid afterwards; rd_data = 0.
